// File: rtl/channel_tx_arbiter.sv
// Round-robin merge of SOURCES producers into one channel stream with an 8-bit source-id header.
// Accept-to-out_valid latency 1 cycle; no source is granted while the output register holds an unaccepted word.
module channel_tx_arbiter #(
  parameter int WIDTH   = 128,
  parameter int SOURCES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SOURCES*(WIDTH-8)-1:0]   src_data,
  input  logic [SOURCES-1:0]             src_valid,
  output logic [SOURCES-1:0]             src_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           has_message_flying,
  output logic [31:0]                    sent_count,
  output logic [31:0]                    stall_cycles
);

  localparam int PAYLOAD_W = WIDTH - 8;
  localparam int PTR_W     = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(SOURCES - 1);

  typedef struct packed {
    logic [7:0]           id;
    logic [PAYLOAD_W-1:0] payload;
  } word_t;

  word_t            out_word;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             grant_found;
  logic             grant_vld;
  logic             load_ok;
  logic             out_valid_nxt;

  assign load_ok = !out_valid || out_ready;

  // Scan from rr_ptr upward with wrap; first valid source wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = rr_ptr;
    for (int i = 0; i < SOURCES; i++) begin
      if (!grant_found && src_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_SRC) ? '0 : scan_idx + 1'b1;
    end
  end

  assign grant_vld = load_ok && grant_found && !reset;

  always_comb begin
    src_ready = '0;
    if (grant_vld) begin
      src_ready[grant_idx] = 1'b1;
    end
  end

  assign out_valid_nxt = grant_vld || (out_valid && !out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid          <= 1'b0;
      out_word           <= '0;
      rr_ptr             <= '0;
      has_message_flying <= 1'b0;
      sent_count         <= '0;
      stall_cycles       <= '0;
    end else begin
      out_valid <= out_valid_nxt;
      if (grant_vld) begin
        out_word.id      <= 8'(grant_idx);
        out_word.payload <= src_data[int'(grant_idx)*PAYLOAD_W +: PAYLOAD_W];
        rr_ptr           <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
      end
      if (out_valid && out_ready) begin
        sent_count <= sent_count + 32'd1;
      end
      if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      has_message_flying <= (|src_valid) || out_valid_nxt;
    end
  end

  assign out_data = out_word;

endmodule
